// File: rtl/sdram_config_regs_pkg.sv
// sdram_config_pkg: shared definitions for the SDRAM configuration register bank.
//   - reg_idx_e       register indices on the data_m bus
//   - STAT_* / CTRL_* bit positions inside STATUS and CONTROL
//   - reinit_state_e  states of the re-initialisation handshake FSM
//   - REINIT_TIMEOUT  terminal value of the reinit timeout counter
package sdram_config_pkg;

    typedef enum logic [1:0] {
        REG_STATUS           = 2'd0,
        REG_CONTROL          = 2'd1,
        REG_REFRESH_INTERVAL = 2'd2,
        REG_REFRESH_COUNT    = 2'd3
    } reg_idx_e;

    localparam int STAT_CONFIG_DONE  = 0;
    localparam int STAT_REINIT_BUSY  = 1;
    localparam int STAT_REINIT_FAIL  = 2;

    localparam int CTRL_REINIT       = 0;
    localparam int CTRL_SELF_REFRESH = 1;
    localparam int CTRL_CLR_FAIL     = 2;

    typedef enum logic [1:0] {
        RS_IDLE      = 2'd0,
        RS_REQ       = 2'd1,
        RS_WAIT_LOW  = 2'd2,
        RS_WAIT_DONE = 2'd3
    } reinit_state_e;

    localparam logic [15:0] REINIT_TIMEOUT = 16'hFFFF;

endpackage

// File: rtl/sdram_config_regs_if.sv
// sdram_config_regs_if: CPU data_m register bus.
//   cs/addr/data_in/bytesel/wr_en/access driven by the CPU side (master),
//   data_out/ack returned by the register bank (slave).
interface sdram_config_regs_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2
);
    logic                    cs;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data_in;
    logic [DATA_WIDTH/8-1:0] bytesel;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    wr_en;
    logic                    access;
    logic                    ack;

    modport master (
        output cs, addr, data_in, bytesel, wr_en, access,
        input  data_out, ack
    );

    modport slave (
        input  cs, addr, data_in, bytesel, wr_en, access,
        output data_out, ack
    );
endinterface

// File: rtl/sdram_config_regs_reinit_fsm.sv
// sdram_reinit_fsm: software-triggered re-initialisation handshake with the
// SDRAM controller, plus a 16-bit timeout and the sticky failure flag.
//   clk, reset      clock, async active-high reset
//   start           committed CONTROL write with REINIT set (ignored unless idle)
//   clr_fail        committed CONTROL write with CLR_FAIL set
//   reinit_ack      controller accepted the request
//   config_done     controller initialisation complete
//   reinit_req      request to the controller (high in REQ only)
//   busy            FSM not idle
//   fail            sticky timeout flag
module sdram_reinit_fsm
    import sdram_config_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clr_fail,
    input  logic reinit_ack,
    input  logic config_done,
    output logic reinit_req,
    output logic busy,
    output logic fail
);
    localparam logic [1:0] ST_IDLE      = RS_IDLE;
    localparam logic [1:0] ST_REQ       = RS_REQ;
    localparam logic [1:0] ST_WAIT_LOW  = RS_WAIT_LOW;
    localparam logic [1:0] ST_WAIT_DONE = RS_WAIT_DONE;

    logic [1:0]  state;
    logic [15:0] tmo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            tmo   <= '0;
            fail  <= 1'b0;
        end else begin
            if (clr_fail)
                fail <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tmo <= '0;
                    if (start)
                        state <= ST_REQ;
                end
                ST_REQ: begin
                    tmo <= '0;
                    if (reinit_ack)
                        state <= ST_WAIT_LOW;
                end
                // The timeout spans both wait states, so it is not cleared
                // between them; expiry takes priority over a normal exit.
                ST_WAIT_LOW, ST_WAIT_DONE: begin
                    tmo <= tmo + 16'd1;
                    if (tmo == REINIT_TIMEOUT) begin
                        state <= ST_IDLE;
                        fail  <= 1'b1;
                    end else if (state == ST_WAIT_LOW && !config_done)
                        state <= ST_WAIT_DONE;
                    else if (state == ST_WAIT_DONE && config_done)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Decoded straight from the state flop so reset drops the request at once.
    assign reinit_req = (state == ST_REQ);
    assign busy       = (state != ST_IDLE);
endmodule

// File: rtl/sdram_config_regs.sv
// sdram_config_regs: SDRAM configuration/status register bank on data_m.
//   clk, reset        clock, async active-high reset
//   bus               data_m register bus (slave side)
//   config_done       controller init complete (sampled once into STATUS)
//   refresh_done      one pulse per completed auto-refresh
//   reinit_req/ack    re-initialisation handshake
//   self_refresh_en   CONTROL.SELF_REFRESH
//   refresh_interval  REFRESH_INTERVAL register
// Optional: SDRAM_CONFIG_REFRESH_COUNT_EN enables the REFRESH_COUNT counter
// at index 3; without it index 3 reads 0 and refresh_done is ignored.
module sdram_config_regs
    import sdram_config_pkg::*;
#(
    parameter int                    DATA_WIDTH             = 16,
    parameter int                    ADDR_WIDTH             = 2,
    parameter logic [DATA_WIDTH-1:0] REFRESH_INTERVAL_RESET = DATA_WIDTH'(16'd780),
    parameter int                    COUNT_WIDTH            = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    sdram_config_regs_if.slave     bus,
    input  logic                   config_done,
    input  logic                   refresh_done,
    output logic                   reinit_req,
    input  logic                   reinit_ack,
    output logic                   self_refresh_en,
    output logic [DATA_WIDTH-1:0]  refresh_interval
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic take, wr, rd;
    logic hit_status, hit_ctrl, hit_ivl, hit_cnt;
    logic ctrl_lo_wr, cfg_done_q, busy, fail;
    logic [DATA_WIDTH-1:0] rdata;
    logic [NUM_BYTES-1:0][7:0] interval_q;

    // ack is high for the cycle after a take, which blocks an immediate
    // re-take of a still-held request.
    assign take = bus.cs && bus.access && !bus.ack;
    assign wr   = take && bus.wr_en;
    assign rd   = take && !bus.wr_en;

    assign hit_status = (bus.addr == ADDR_WIDTH'(REG_STATUS));
    assign hit_ctrl   = (bus.addr == ADDR_WIDTH'(REG_CONTROL));
    assign hit_ivl    = (bus.addr == ADDR_WIDTH'(REG_REFRESH_INTERVAL));
    assign hit_cnt    = (bus.addr == ADDR_WIDTH'(REG_REFRESH_COUNT));

    // All CONTROL bits live in byte lane 0.
    assign ctrl_lo_wr = wr && hit_ctrl && bus.bytesel[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ack         <= 1'b0;
            bus.data_out    <= '0;
            cfg_done_q      <= 1'b0;
            self_refresh_en <= 1'b0;
        end else begin
            bus.ack      <= take;
            bus.data_out <= rd ? rdata : '0;
            cfg_done_q   <= config_done;
            if (ctrl_lo_wr)
                self_refresh_en <= bus.data_in[CTRL_SELF_REFRESH];
        end
    end

    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                interval_q[g] <= REFRESH_INTERVAL_RESET[g*8 +: 8];
            else if (wr && hit_ivl && bus.bytesel[g])
                interval_q[g] <= bus.data_in[g*8 +: 8];
        end
    end
    assign refresh_interval = interval_q;

`ifdef SDRAM_CONFIG_REFRESH_COUNT_EN
    logic [COUNT_WIDTH-1:0] refresh_cnt;

    // A clearing write beats a coincident refresh pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            refresh_cnt <= '0;
        else if (wr && hit_cnt)
            refresh_cnt <= '0;
        else if (refresh_done && refresh_cnt != '1)
            refresh_cnt <= refresh_cnt + 1'b1;
    end
`else
    logic unused_refresh_done;
    assign unused_refresh_done = refresh_done;
`endif

    always_comb begin
        rdata = '0;
        if (hit_status) begin
            rdata[STAT_CONFIG_DONE] = cfg_done_q;
            rdata[STAT_REINIT_BUSY] = busy;
            rdata[STAT_REINIT_FAIL] = fail;
        end else if (hit_ctrl) begin
            rdata[CTRL_SELF_REFRESH] = self_refresh_en;
        end else if (hit_ivl) begin
            rdata = interval_q;
        end
`ifdef SDRAM_CONFIG_REFRESH_COUNT_EN
        else if (hit_cnt) begin
            rdata = DATA_WIDTH'(refresh_cnt);
        end
`endif
    end

    sdram_reinit_fsm u_reinit (
        .clk         (clk),
        .reset       (reset),
        .start       (ctrl_lo_wr && bus.data_in[CTRL_REINIT]),
        .clr_fail    (ctrl_lo_wr && bus.data_in[CTRL_CLR_FAIL]),
        .reinit_ack  (reinit_ack),
        .config_done (config_done),
        .reinit_req  (reinit_req),
        .busy        (busy),
        .fail        (fail)
    );
endmodule

// File: tb/tb_sdram_config_regs.sv
// Scoreboard bench for sdram_config_regs: stimulus pushes expected read data,
// a negedge monitor pops it whenever ack is seen.
module tb_sdram_config_regs;
    logic        clk = 1'b0;
    logic        reset;
    logic        config_done, refresh_done, reinit_ack;
    logic        reinit_req, self_refresh_en;
    logic [15:0] refresh_interval;

    sdram_config_regs_if #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) bus ();

    sdram_config_regs dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .config_done      (config_done),
        .refresh_done     (refresh_done),
        .reinit_req       (reinit_req),
        .reinit_ack       (reinit_ack),
        .self_refresh_en  (self_refresh_en),
        .refresh_interval (refresh_interval)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    // Reference model state, in register-map terms.
    logic [15:0] m_interval;
    bit          m_selfref, m_cfg, m_busy, m_fail;
    int unsigned m_count;

`ifdef SDRAM_CONFIG_REFRESH_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input int a);
        case (a)
            0: return {13'd0, m_fail, m_busy, m_cfg};
            1: return {14'd0, m_selfref, 1'b0};
            2: return m_interval;
            3: return CNT_EN ? m_count[15:0] : 16'd0;
            default: return 16'd0;
        endcase
    endfunction

    task automatic model_write(input int a, input logic [15:0] d, input logic [1:0] bs);
        case (a)
            1: if (bs[0]) begin
                m_selfref = d[1];
                if (d[2]) m_fail = 1'b0;
                if (d[0] && !m_busy) m_busy = 1'b1;
            end
            2: begin
                if (bs[0]) m_interval[7:0]  = d[7:0];
                if (bs[1]) m_interval[15:8] = d[15:8];
            end
            3: m_count = 0;
            default: ;
        endcase
    endtask

    task automatic wait_idle();
        if (bus.ack) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns in the ack cycle (posedge+1).
    task automatic bus_op(input bit wr, input int a, input logic [15:0] d,
                          input logic [1:0] bs, input bit with_ref, output int lat);
        wait_idle();
        if (wr) begin
            exp_q.push_back(16'd0);
            model_write(a, d, bs);
        end else
            exp_q.push_back(model_read(a));
        bus.cs = 1'b1; bus.access = 1'b1; bus.wr_en = wr;
        bus.addr = a[1:0]; bus.data_in = d; bus.bytesel = bs;
        if (with_ref) refresh_done = 1'b1;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            refresh_done = 1'b0;
            if (bus.ack) begin
                lat = i + 1;
                break;
            end
        end
        if (lat == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: got no ack expected ack within 8 cycles");
        end
        bus.cs = 1'b0; bus.access = 1'b0; bus.wr_en = 1'b0;
    endtask

    task automatic refresh_pulse();
        refresh_done = 1'b1;
        step(1);
        refresh_done = 1'b0;
        if (m_count != 32'hFFFF) m_count++;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ack) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_ack: got ack expected none (data 0x%0h)", bus.data_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("read_data", {16'd0, bus.data_out}, {16'd0, mon_exp});
                end
            end else
                check("idle_data_zero", {16'd0, bus.data_out}, 32'd0);
        end
    end

    initial begin
        int lat, acks, op, a;
        bit prev, adj;
        logic [15:0] d;
        reset = 1'b1; config_done = 1'b1; refresh_done = 1'b0; reinit_ack = 1'b0;
        bus.cs = 1'b0; bus.access = 1'b0; bus.wr_en = 1'b0;
        bus.addr = '0; bus.data_in = '0; bus.bytesel = '0;
        m_interval = 16'h030C; m_selfref = 0; m_cfg = 1; m_busy = 0; m_fail = 0; m_count = 0;
        #1;
        check("rst_ack", {31'd0, bus.ack}, 0);
        check("rst_data_out", {16'd0, bus.data_out}, 0);
        check("rst_reinit_req", {31'd0, reinit_req}, 0);
        check("rst_self_refresh", {31'd0, self_refresh_en}, 0);
        check("rst_interval", {16'd0, refresh_interval}, 32'h030C);
        step(3);
        reset = 1'b0;
        step(2);

        // Reset-value read and latency.
        bus_op(0, 2, 16'h0, 2'b11, 0, lat);
        check("read_latency", lat, 1);

        // Upper-lane-only write.
        bus_op(1, 2, 16'hABCD, 2'b10, 0, lat);
        check("interval_port_lane", {16'd0, refresh_interval}, 32'hAB0C);
        bus_op(0, 2, 16'h0, 2'b11, 0, lat);

        // Held request: two acks, never adjacent.
        wait_idle();
        exp_q.push_back(model_read(2));
        exp_q.push_back(model_read(2));
        bus.cs = 1; bus.access = 1; bus.wr_en = 0; bus.addr = 2'd2; bus.bytesel = 2'b11;
        acks = 0; prev = 0; adj = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.ack) begin
                acks++;
                if (prev) adj = 1;
            end
            prev = bus.ack;
        end
        bus.cs = 0; bus.access = 0;
        check("hold_ack_count", acks, 2);
        check("hold_ack_adjacent", {31'd0, adj}, 0);

        // Normal reinit handshake.
        bus_op(1, 1, 16'h0001, 2'b11, 0, lat);
        check("reinit_req_raised", {31'd0, reinit_req}, 1);
        bus_op(0, 0, 16'h0, 2'b11, 0, lat);
        step(5);
        reinit_ack = 1'b1;
        step(1);
        reinit_ack = 1'b0;
        check("reinit_req_dropped", {31'd0, reinit_req}, 0);
        config_done = 1'b0;
        step(2);
        m_cfg = 0;
        bus_op(0, 0, 16'h0, 2'b11, 0, lat);
        step(6);
        config_done = 1'b1;
        step(3);
        m_cfg = 1; m_busy = 0;
        bus_op(0, 0, 16'h0, 2'b11, 0, lat);

        // Randomized register traffic.
        for (int n = 0; n < 200; n++) begin
            op = int'($urandom_range(0, 4));
            a  = int'($urandom_range(0, 3));
            d  = 16'($urandom);
            case (op)
                0, 1: bus_op(0, a, 16'h0, 2'($urandom), 0, lat);
                2: begin
                    if (a == 1) d[0] = 1'b0;   // never trigger reinit here
                    bus_op(1, a, d, 2'($urandom), 0, lat);
                    check("interval_port", {16'd0, refresh_interval}, {16'd0, m_interval});
                    check("self_refresh_port", {31'd0, self_refresh_en}, {31'd0, m_selfref});
                end
                3: refresh_pulse();
                default: begin
                    wait_idle();
                    bus.cs = 0; bus.access = 1;  // not selected: no ack
                    step(2);
                    bus.access = 0;
                end
            endcase
        end

        // Refresh counter: three pulses, then a clear racing a pulse.
        bus_op(1, 3, 16'h0, 2'b11, 0, lat);
        step(1);
        refresh_pulse(); refresh_pulse(); refresh_pulse();
        bus_op(0, 3, 16'h0, 2'b11, 0, lat);
        bus_op(1, 3, 16'h0, 2'b11, 1, lat);
        step(1);
        bus_op(0, 3, 16'h0, 2'b11, 0, lat);

        // Reinit timeout: config_done never drops.
        bus_op(1, 1, 16'h0001, 2'b11, 0, lat);
        step(3);
        reinit_ack = 1'b1;
        step(1);
        reinit_ack = 1'b0;
        step(65600);
        m_busy = 0; m_fail = 1;
        bus_op(0, 0, 16'h0, 2'b11, 0, lat);
        bus_op(1, 1, 16'h0004, 2'b11, 0, lat);
        bus_op(0, 0, 16'h0, 2'b11, 0, lat);
        check("self_refresh_after_clear", {31'd0, self_refresh_en}, 0);

        // Reset while in REQ with ack high.
        wait_idle();
        step(1);
        bus.cs = 1; bus.access = 1; bus.wr_en = 1; bus.addr = 2'd1;
        bus.data_in = 16'h0003; bus.bytesel = 2'b11;
        step(1);
        bus.cs = 0; bus.access = 0; bus.wr_en = 0;
        check("pre_rst_ack", {31'd0, bus.ack}, 1);
        check("pre_rst_reinit_req", {31'd0, reinit_req}, 1);
        check("pre_rst_self_refresh", {31'd0, self_refresh_en}, 1);
        reset = 1'b1;
        #1;
        check("async_rst_ack", {31'd0, bus.ack}, 0);
        check("async_rst_reinit_req", {31'd0, reinit_req}, 0);
        check("async_rst_self_refresh", {31'd0, self_refresh_en}, 0);
        check("async_rst_interval", {16'd0, refresh_interval}, 32'h030C);
        step(2);
        reset = 1'b0;
        step(2);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sdram_config_regs.md
Name: sdram_config_regs

Overview:
- Parametrised SDRAM configuration/status register bank on the data_m bus; successor to the single-bit config-done status register.
- Adds multiple addressed registers, byte-lane writes, a writable refresh interval, a software-triggered re-init handshake with the SDRAM controller, and a refresh event counter.
- Sits between the CPU data bus decoder (cs) and the SDRAM controller's config/refresh interface.

Parameters:
- DATA_WIDTH, 16, bus data width; multiple of 8, at least 16.
- ADDR_WIDTH, 2, register index width; registers at or above index 4 read 0, writes ignored.
- REFRESH_INTERVAL_RESET, 16'd780, reset value of the refresh interval register, in clk cycles.
- COUNT_WIDTH, 16, refresh counter width; at most DATA_WIDTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  register bank selected by the address decoder.
- data_m_addr  in  ADDR_WIDTH  register index.
- data_m_data_in  in  DATA_WIDTH  write data.
- data_m_bytesel  in  DATA_WIDTH/8  byte-lane write enables.
- data_m_data_out  out  DATA_WIDTH  read data; 0 when not returning a read.
- data_m_wr_en  in  1  1 = write, 0 = read.
- data_m_access  in  1  access request; held until ack.
- data_m_ack  out  1  one-cycle access completion.
- config_done  in  1  SDRAM controller initialisation complete.
- refresh_done  in  1  one-cycle pulse per completed auto-refresh.
- reinit_req  out  1  request to the controller to rerun initialisation.
- reinit_ack  in  1  controller accepted reinit_req.
- self_refresh_en  out  1  request self-refresh mode.
- refresh_interval  out  DATA_WIDTH  refresh period to the controller.

Behaviour:
- Register map, by index:
  - 0 STATUS (RO): bit0 config_done (synchronous sample), bit1 reinit_busy (FSM not IDLE), bit2 reinit_fail (sticky), other bits 0.
  - 1 CONTROL (RW): bit0 REINIT, write-1-to-trigger, always reads 0; bit1 SELF_REFRESH drives self_refresh_en. Writing 1 to bit2 clears reinit_fail.
  - 2 REFRESH_INTERVAL (RW, byte-lane): drives refresh_interval.
  - 3 REFRESH_COUNT (RO counter; any write clears it).
- Bus timing:
  - Access is taken when cs && data_m_access && !data_m_ack.
  - data_m_ack is registered and asserts exactly 1 cycle after the access is taken, for 1 cycle.
  - The cycle after ack is never a new access, so a held request cannot double-write.
  - Read data is registered in the same cycle as ack; data_m_data_out is 0 in all other cycles.
  - Writes commit on the clock edge that raises ack. Only lanes with data_m_bytesel set are updated.
- Reinit FSM:
  - IDLE: a committed CONTROL write with bit0 = 1 moves to REQ. The write is ignored if the FSM is not IDLE.
  - REQ: reinit_req = 1; on reinit_ack go to WAIT_LOW.
  - WAIT_LOW: wait for config_done = 0, then WAIT_DONE.
  - WAIT_DONE: on config_done = 1 go to IDLE.
  - Timeout: a 16-bit timeout counter runs in WAIT_LOW and WAIT_DONE. At 0xFFFF it sets reinit_fail and returns to IDLE.
- Refresh counter:
  - Increments on refresh_done and saturates at all-ones.
  - A clearing write wins over a simultaneous refresh_done; the count becomes 0.
- Reset values, asynchronous:
  - data_m_ack = 0, data_m_data_out = 0, reinit_req = 0, self_refresh_en = 0.
  - refresh_interval = REFRESH_INTERVAL_RESET, counter = 0, reinit_fail = 0, FSM = IDLE.
  - Reset mid-handshake drops reinit_req immediately.
- Reads of config_done use a 2-flop synchroniser only if the controller is on another clock. In this block it is the same clock, so there is no synchroniser and one register stage.

Optional Feature:
- Macro: SDRAM_CONFIG_REFRESH_COUNT_EN.
- Defined: REFRESH_COUNT is implemented as above.
- Undefined: no counter logic, index 3 reads 0, writes are acked and ignored, refresh_done is unused.

Decomposition:
- Package sdram_config_pkg holds:
  - the register index enum (REG_STATUS, REG_CONTROL, REG_REFRESH_INTERVAL, REG_REFRESH_COUNT);
  - STATUS/CONTROL bit-position constants;
  - the reinit FSM state enum;
  - the timeout limit.
- One sub-module: sdram_reinit_fsm (FSM plus timeout counter). The register decode stays in the top.

Test Plan:
- Reset, then read index 2 with all bytesel -> ack 1 cycle after access; data 0x030C; data_m_data_out 0 the cycle before and the cycle after.
- Write 0xABCD to index 2 with bytesel = 2'b10, then read -> 0xAB0C; refresh_interval = 0xAB0C. Hold data_m_access for 4 cycles -> exactly two acks, non-adjacent.
- Write CONTROL = 0x1 -> reinit_req high the next cycle. Hold off reinit_ack 5 cycles, then pulse it; drop config_done, raise it 10 cycles later -> STATUS reads 0x1 after, and 0x2 mid-sequence.
- Reinit with config_done never dropping -> after 65535 cycles STATUS = 0x5 (reinit_fail set); write CONTROL = 0x4 -> STATUS = 0x1.
- With SDRAM_CONFIG_REFRESH_COUNT_EN: 3 refresh_done pulses -> index 3 reads 3; clearing write coincident with refresh_done -> reads 0. Without the macro -> index 3 always reads 0.
- Assert reset while in REQ -> reinit_req, data_m_ack, self_refresh_en fall asynchronously; refresh_interval returns to 0x030C.
